fc_mac_feeder: RTL and testbench
================================

# fc_mac_feeder

Sequencer that drives the fully-connected layer's `multiplier_accumulator`. It streams activation and weight windows from SRAM into the MAC, pulses `accumulate_reset` at each neuron boundary, and captures the finished 32-bit sums. It sits between the FC activation/weight SRAMs and the MAC. Every output neuron is produced with no bubbles between neurons.

## Interface
Parameters:
- `DATA_WIDTH`, 8, activation width
- `WEIGHT_WIDTH`, 4, weight width
- `MAC_NUM`, 20, lanes per window
- `WIN_NUM`, 40, windows per neuron (input length = `WIN_NUM*MAC_NUM`)
- `OUT_NUM`, 500, output neurons
- `ACT_AW`, 6, activation SRAM address width
- `WGT_AW`, 15, weight SRAM address width

Ports:
- `clk` in 1: single clock, rising edge.
- `srstn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a layer; ignored while `busy`.
- `sram_raddr_act` out `ACT_AW`: activation read address.
- `sram_rdata_act` in `MAC_NUM*DATA_WIDTH`: activation data, valid 1 cycle after the address.
- `sram_raddr_weight` out `WGT_AW`: weight read address.
- `sram_rdata_weight` in `MAC_NUM*WEIGHT_WIDTH`: weight data, valid 1 cycle after the address.
- `src_window` out `MAC_NUM*DATA_WIDTH`: registered activations to the MAC.
- `weight_window` out `MAC_NUM*WEIGHT_WIDTH`: registered weights to the MAC.
- `accumulate_reset` out 1: high with the first window of each neuron.
- `mac_data_out` in 32 signed: MAC accumulator, registered inside the MAC.
- `result` out 32 signed: captured neuron sum.
- `result_valid` out 1: one-cycle pulse per neuron.
- `result_idx` out 16: neuron index of `result`.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle pulse after the last result.

## Operation
- FSM states: `IDLE`, `RUN`, `DRAIN`, `DONE`.
  - `IDLE` -> `RUN` on `start`.
  - `RUN` -> `DRAIN` after the address for (`out_cnt=OUT_NUM-1`, `win_cnt=WIN_NUM-1`) is issued.
  - `DRAIN` lasts 3 cycles, to flush the pipeline.
  - `DRAIN` -> `DONE` -> `IDLE`, with `DONE` lasting 1 cycle.
- Counters:
  - `win_cnt` counts 0..`WIN_NUM-1` and wraps, incrementing `out_cnt`.
  - `out_cnt` counts 0..`OUT_NUM-1`.
  - Both advance every `RUN` cycle.
- Addresses:
  - `sram_raddr_act = win_cnt`.
  - `sram_raddr_weight` starts at 0 and increments by 1 every `RUN` cycle, so it equals `out_cnt*WIN_NUM+win_cnt`. It is never multiplied.
- Pipeline stages: A (address) -> D (SRAM data) -> W (window registers to MAC) -> R (MAC sum visible on `mac_data_out`).
  - A `first` tag (`win_cnt==0`), a `last` tag (`win_cnt==WIN_NUM-1`) and a valid bit are carried alongside each stage.
- `accumulate_reset` is the W-stage `first` tag.
  - The MAC is defined to load, not add, on a cycle where `accumulate_reset` is high.
- Capture:
  - When the R-stage `last` tag is high, `result <= mac_data_out` and `result_valid` pulses.
  - `result_idx` takes the neuron index carried with the tag.
- Back-to-back neurons: neuron n's R cycle coincides with neuron n+1's first W cycle. This is legal because the MAC reloads only at the following edge.
- Invalid W stages drive zero windows with `accumulate_reset` low.
- `start` during `busy`: ignored.
- `srstn` low mid-layer: all state is cleared immediately and no partial `result_valid` or `done` is emitted.
- Reset values of all outputs:
  - addresses, windows and `result` = 0;
  - `accumulate_reset`, `result_valid`, `result_idx`, `busy`, `done` = 0.

## Timing
- `start` at cycle 0: first address at cycle 1, first window at cycle 3 with `accumulate_reset`=1.
- First `result_valid` at cycle `WIN_NUM+3`.
- Neuron k's result arrives at cycle `(k+1)*WIN_NUM+3`.
- `done` arrives at cycle `OUT_NUM*WIN_NUM+4`, one cycle after the last `result_valid`.
- Throughput is one window per cycle, with no stalls.

## Configuration
- `FC_RELU_EN` defined: the captured value is clamped, `result = (mac_data_out<0) ? 0 : mac_data_out`.
- `FC_RELU_EN` undefined: the raw signed sum is passed through.
- Timing is identical in both cases.

## Structure
- Package `fc_pkg` holds:
  - the FSM state enum;
  - `DATA_WIDTH`, `WEIGHT_WIDTH`, `MAC_NUM`, `WIN_NUM`, `OUT_NUM` defaults;
  - the 32-bit accumulator type.
- One sub-module, `fc_addr_gen`: the `win_cnt`/`out_cnt` counters, address generation, and `first`/`last`/valid tag generation.
- Pipeline tags, window registers and result capture stay in `fc_mac_feeder`.

## Test plan
- Bench parameters `WIN_NUM=2`, `OUT_NUM=3` with a behavioural MAC; all activations=1, all weights=1, `start` at cycle 0 -> `result`=40 for idx 0,1,2 at cycles 5, 7, 9; `done` at cycle 10.
- Weights set to -1 for neuron 1 only -> idx 1 `result`=-40 without `FC_RELU_EN`, 0 with it.
- Address check -> `sram_raddr_weight` sequence is 0,1,2,3,4,5 and `sram_raddr_act` is 0,1,0,1,0,1 on cycles 1..6.
- `start` pulsed again at cycle 4 -> ignored; exactly 3 `result_valid` pulses and 1 `done`.
- `srstn` low at cycle 6 for 1 cycle -> all outputs 0 in that cycle; no further `result_valid`; a new `start` runs cleanly from idx 0.
- `accumulate_reset` check -> high exactly on cycles 3, 5, 7, coincident with `result_valid` on cycles 5 and 7.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and default geometry for the fully-connected MAC feeder.
package fc_pkg;

  localparam int FC_DATA_WIDTH   = 8;
  localparam int FC_WEIGHT_WIDTH = 4;
  localparam int FC_MAC_NUM      = 20;
  localparam int FC_WIN_NUM      = 40;
  localparam int FC_OUT_NUM      = 500;
  localparam int FC_ACT_AW       = 6;
  localparam int FC_WGT_AW       = 15;
  localparam int FC_IDX_W        = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fc_state_e;

  typedef logic signed [31:0] fc_acc_t;

endpackage

// File: rtl/fc_addr_gen.sv
// Window/neuron counters for the FC feeder: SRAM read addresses plus the
// first/last/final tags that travel down the pipeline with each address.
module fc_addr_gen
  import fc_pkg::*;
#(
  parameter int ACT_AW  = FC_ACT_AW,
  parameter int WGT_AW  = FC_WGT_AW,
  parameter int WIN_NUM = FC_WIN_NUM,
  parameter int OUT_NUM = FC_OUT_NUM
) (
  input  logic                clk,
  input  logic                srstn,
  input  logic                run_i,
  output logic [ACT_AW-1:0]   act_addr_o,
  output logic [WGT_AW-1:0]   wgt_addr_o,
  output logic                first_o,
  output logic                last_o,
  output logic                final_o,
  output logic [FC_IDX_W-1:0] idx_o
);

  localparam logic [ACT_AW-1:0]   WIN_LAST = ACT_AW'(WIN_NUM - 1);
  localparam logic [FC_IDX_W-1:0] OUT_LAST = FC_IDX_W'(OUT_NUM - 1);

  logic [ACT_AW-1:0]   win_q, win_d;
  logic [FC_IDX_W-1:0] out_q, out_d;
  logic [WGT_AW-1:0]   waddr_q, waddr_d;
  logic                last_s;
  logic                final_s;

  assign last_s  = (win_q == WIN_LAST);
  assign final_s = last_s && (out_q == OUT_LAST);

  // The weight address is a free-running count, never out_cnt*WIN_NUM.
  always_comb begin
    win_d   = win_q;
    out_d   = out_q;
    waddr_d = waddr_q;
    if (run_i) begin
      if (final_s) begin
        win_d   = {ACT_AW{1'b0}};
        out_d   = {FC_IDX_W{1'b0}};
        waddr_d = {WGT_AW{1'b0}};
      end else if (last_s) begin
        win_d   = {ACT_AW{1'b0}};
        out_d   = out_q + FC_IDX_W'(1);
        waddr_d = waddr_q + WGT_AW'(1);
      end else begin
        win_d   = win_q + ACT_AW'(1);
        waddr_d = waddr_q + WGT_AW'(1);
      end
    end else begin
      win_d   = win_q;
      out_d   = out_q;
      waddr_d = waddr_q;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      win_q   <= {ACT_AW{1'b0}};
      out_q   <= {FC_IDX_W{1'b0}};
      waddr_q <= {WGT_AW{1'b0}};
    end else begin
      win_q   <= win_d;
      out_q   <= out_d;
      waddr_q <= waddr_d;
    end
  end

  assign act_addr_o = win_q;
  assign wgt_addr_o = waddr_q;
  assign first_o    = (win_q == {ACT_AW{1'b0}});
  assign last_o     = last_s;
  assign final_o    = final_s;
  assign idx_o      = out_q;

endmodule

// File: rtl/fc_mac_feeder.sv
// Streams activation/weight windows from SRAM into the FC-layer MAC and captures
// one 32-bit sum per output neuron. Define FC_RELU_EN to clamp negative sums to 0.
module fc_mac_feeder
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH   = FC_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = FC_WEIGHT_WIDTH,
  parameter int MAC_NUM      = FC_MAC_NUM,
  parameter int WIN_NUM      = FC_WIN_NUM,
  parameter int OUT_NUM      = FC_OUT_NUM,
  parameter int ACT_AW       = FC_ACT_AW,
  parameter int WGT_AW       = FC_WGT_AW
) (
  input  logic                             clk,
  input  logic                             srstn,
  input  logic                             start,
  output logic [ACT_AW-1:0]                sram_raddr_act,
  input  logic [MAC_NUM*DATA_WIDTH-1:0]    sram_rdata_act,
  output logic [WGT_AW-1:0]                sram_raddr_weight,
  input  logic [MAC_NUM*WEIGHT_WIDTH-1:0]  sram_rdata_weight,
  output logic [MAC_NUM*DATA_WIDTH-1:0]    src_window,
  output logic [MAC_NUM*WEIGHT_WIDTH-1:0]  weight_window,
  output logic                             accumulate_reset,
  input  logic signed [31:0]               mac_data_out,
  output logic signed [31:0]               result,
  output logic                             result_valid,
  output logic [15:0]                      result_idx,
  output logic                             busy,
  output logic                             done
);

  fc_state_e           state_q, state_d;
  logic [1:0]          drain_q, drain_d;
  logic                run_s;
  logic                a_first_s, a_last_s, a_final_s;
  logic [FC_IDX_W-1:0] a_idx_s;

  logic                d_valid_q, d_first_q, d_last_q;
  logic [FC_IDX_W-1:0] d_idx_q;

  logic [MAC_NUM*DATA_WIDTH-1:0]   src_q;
  logic [MAC_NUM*WEIGHT_WIDTH-1:0] wgt_q;
  logic                            acc_reset_q;
  logic                            w_fire_q;
  logic [FC_IDX_W-1:0]             w_idx_q;

  logic                result_valid_q;
  logic [FC_IDX_W-1:0] result_idx_q;
  fc_acc_t             result_hold_q;
  fc_acc_t             capture_s;
  logic                busy_q, done_q;

  assign run_s = (state_q == RUN);

  fc_addr_gen #(
    .ACT_AW  (ACT_AW),
    .WGT_AW  (WGT_AW),
    .WIN_NUM (WIN_NUM),
    .OUT_NUM (OUT_NUM)
  ) u_addr_gen (
    .clk        (clk),
    .srstn      (srstn),
    .run_i      (run_s),
    .act_addr_o (sram_raddr_act),
    .wgt_addr_o (sram_raddr_weight),
    .first_o    (a_first_s),
    .last_o     (a_last_s),
    .final_o    (a_final_s),
    .idx_o      (a_idx_s)
  );

  // Layer sequencing; DRAIN covers the D, W and R stages behind the last address.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      RUN: begin
        drain_d = 2'd0;
        if (a_final_s) state_d = DRAIN;
        else           state_d = RUN;
      end
      DRAIN: begin
        if (drain_q == 2'd2) state_d = DONE;
        else                 drain_d = drain_q + 2'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q <= IDLE;
      drain_q <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      busy_q  <= (state_d == RUN) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
    end
  end

  // Tags ride alongside the data: A -> D -> W -> R.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      d_valid_q      <= 1'b0;
      d_first_q      <= 1'b0;
      d_last_q       <= 1'b0;
      d_idx_q        <= {FC_IDX_W{1'b0}};
      src_q          <= '0;
      wgt_q          <= '0;
      acc_reset_q    <= 1'b0;
      w_fire_q       <= 1'b0;
      w_idx_q        <= {FC_IDX_W{1'b0}};
      result_valid_q <= 1'b0;
      result_idx_q   <= {FC_IDX_W{1'b0}};
      result_hold_q  <= 32'sd0;
    end else begin
      d_valid_q      <= run_s;
      d_first_q      <= run_s & a_first_s;
      d_last_q       <= run_s & a_last_s;
      d_idx_q        <= a_idx_s;
      src_q          <= d_valid_q ? sram_rdata_act : '0;
      wgt_q          <= d_valid_q ? sram_rdata_weight : '0;
      acc_reset_q    <= d_valid_q & d_first_q;
      w_fire_q       <= d_valid_q & d_last_q;
      w_idx_q        <= d_idx_q;
      result_valid_q <= w_fire_q;
      result_idx_q   <= w_fire_q ? w_idx_q : result_idx_q;
      result_hold_q  <= result_valid_q ? capture_s : result_hold_q;
    end
  end

`ifdef FC_RELU_EN
  assign capture_s = mac_data_out[31] ? 32'sd0 : mac_data_out;
`else
  assign capture_s = mac_data_out;
`endif

  // The finished sum is only on mac_data_out during the R cycle, so it is
  // passed straight through then and held from the register afterwards.
  assign result            = result_valid_q ? capture_s : result_hold_q;
  assign result_valid      = result_valid_q;
  assign result_idx        = result_idx_q;
  assign src_window        = src_q;
  assign weight_window     = wgt_q;
  assign accumulate_reset  = acc_reset_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_fc_mac_feeder.sv
// Directed bench for fc_mac_feeder with WIN_NUM=2, OUT_NUM=3, a behavioural MAC and SRAMs.
module tb_fc_mac_feeder;

  localparam int DW = 8;
  localparam int WW = 4;
  localparam int MN = 20;

  logic                clk = 1'b0;
  logic                srstn = 1'b0;
  logic                start = 1'b0;
  logic [5:0]          sram_raddr_act;
  logic [MN*DW-1:0]    sram_rdata_act = '0;
  logic [14:0]         sram_raddr_weight;
  logic [MN*WW-1:0]    sram_rdata_weight = '0;
  logic [MN*DW-1:0]    src_window;
  logic [MN*WW-1:0]    weight_window;
  logic                accumulate_reset;
  logic signed [31:0]  mac_data_out = 32'sd0;
  logic signed [31:0]  result;
  logic                result_valid;
  logic [15:0]         result_idx;
  logic                busy;
  logic                done;

  int total = 0;
  int bad = 0;
  int rv_cnt = 0;
  int done_cnt = 0;
  bit neg_mode = 1'b0;
  int dot;

  logic [MN*DW-1:0] act_ones;
  logic [MN*WW-1:0] wgt_ones;
  logic [MN*WW-1:0] wgt_negs;

  fc_mac_feeder #(
    .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .MAC_NUM(MN),
    .WIN_NUM(2), .OUT_NUM(3), .ACT_AW(6), .WGT_AW(15)
  ) dut (
    .clk(clk), .srstn(srstn), .start(start),
    .sram_raddr_act(sram_raddr_act), .sram_rdata_act(sram_rdata_act),
    .sram_raddr_weight(sram_raddr_weight), .sram_rdata_weight(sram_rdata_weight),
    .src_window(src_window), .weight_window(weight_window),
    .accumulate_reset(accumulate_reset), .mac_data_out(mac_data_out),
    .result(result), .result_valid(result_valid), .result_idx(result_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // SRAMs: one-cycle read latency; weights of neuron 1 (addresses 2,3) go to -1 in neg_mode.
  always @(posedge clk) begin
    sram_rdata_act    <= act_ones;
    sram_rdata_weight <= (neg_mode && (sram_raddr_weight == 15'd2 || sram_raddr_weight == 15'd3))
                         ? wgt_negs : wgt_ones;
  end

  always_comb begin
    dot = 0;
    for (int i = 0; i < MN; i++)
      dot += int'($signed(src_window[i*DW +: DW])) * int'($signed(weight_window[i*WW +: WW]));
  end

  // Behavioural MAC: loads on accumulate_reset, otherwise adds.
  always @(posedge clk) begin
    if (accumulate_reset) mac_data_out <= dot;
    else                  mac_data_out <= mac_data_out + dot;
  end

  always @(negedge clk) begin
    if (result_valid) rv_cnt++;
    if (done)         done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input logic [MN*DW-1:0] obs_a, input logic [MN*DW-1:0] exp_a,
                         input logic [MN*WW-1:0] obs_w, input logic [MN*WW-1:0] exp_w);
    total++;
    assert (obs_a === exp_a && obs_w === exp_w) else begin
      bad++;
      $error("FAIL %s observed act=%0h wgt=%0h expected act=%0h wgt=%0h", tag, obs_a, obs_w, exp_a, exp_w);
    end
  endtask

  // Runs one layer from a start pulse in cycle 0 and checks cycles 1..12.
  task automatic run_layer(input bit repulse, input bit neg, input int mid,
                           input int prev_res, input int prev_idx);
    int held_res, held_idx, rv0, dn0;
    bit in_run;
    held_res = prev_res;
    held_idx = prev_idx;
    rv0 = rv_cnt;
    dn0 = done_cnt;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = (repulse && c == 4);
      in_run = (c >= 1 && c <= 6);
      if (c == 5 || c == 7 || c == 9) begin
        held_idx = (c - 5) / 2;
        held_res = (c == 7) ? mid : 40;
      end
      chk($sformatf("raddr_act c%0d", c), int'(sram_raddr_act), in_run ? (c - 1) % 2 : 0);
      chk($sformatf("raddr_wgt c%0d", c), int'(sram_raddr_weight), in_run ? c - 1 : 0);
      chk($sformatf("acc_reset c%0d", c), int'(accumulate_reset), (c == 3 || c == 5 || c == 7) ? 1 : 0);
      chk($sformatf("res_valid c%0d", c), int'(result_valid), (c == 5 || c == 7 || c == 9) ? 1 : 0);
      chk($sformatf("result c%0d", c), int'(result), held_res);
      chk($sformatf("res_idx c%0d", c), int'(result_idx), held_idx);
      chk($sformatf("busy c%0d", c), int'(busy), (c >= 1 && c <= 9) ? 1 : 0);
      chk($sformatf("done c%0d", c), int'(done), (c == 10) ? 1 : 0);
      if (c == 3) chk_win("window c3", src_window, act_ones, weight_window, wgt_ones);
      if (c == 5) chk_win("window c5", src_window, act_ones, weight_window, neg ? wgt_negs : wgt_ones);
      if (c == 11) chk_win("window c11", src_window, '0, weight_window, '0);
    end
    chk("valid_pulses", rv_cnt - rv0, 3);
    chk("done_pulses", done_cnt - dn0, 1);
  endtask

  initial begin
    int rv0, dn0;
    act_ones = {MN{8'h01}};
    wgt_ones = {MN{4'h1}};
    wgt_negs = {MN{4'hF}};

    // Reset state.
    tick();
    tick();
    chk("rst raddr_act", int'(sram_raddr_act), 0);
    chk("rst raddr_wgt", int'(sram_raddr_weight), 0);
    chk("rst acc_reset", int'(accumulate_reset), 0);
    chk("rst result", int'(result), 0);
    chk("rst res_valid", int'(result_valid), 0);
    chk("rst res_idx", int'(result_idx), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk_win("rst window", src_window, '0, weight_window, '0);
    #2 srstn = 1'b1;
    tick();
    tick();

    // All ones, with a stray start at cycle 4.
    run_layer(1'b1, 1'b0, 40, 0, 0);
    tick();

    // Neuron 1 weights negative.
    neg_mode = 1'b1;
`ifdef FC_RELU_EN
    run_layer(1'b0, 1'b1, 0, 40, 2);
`else
    run_layer(1'b0, 1'b1, -40, 40, 2);
`endif
    neg_mode = 1'b0;
    tick();

    // Reset mid-layer in cycle 6.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 5; c++) tick();
    chk("pre-rst res_valid c5", int'(result_valid), 1);
    chk("pre-rst res_idx c5", int'(result_idx), 0);
    tick();
    srstn = 1'b0;
    #1;
    chk("mid-rst raddr_act", int'(sram_raddr_act), 0);
    chk("mid-rst raddr_wgt", int'(sram_raddr_weight), 0);
    chk("mid-rst acc_reset", int'(accumulate_reset), 0);
    chk("mid-rst result", int'(result), 0);
    chk("mid-rst res_valid", int'(result_valid), 0);
    chk("mid-rst res_idx", int'(result_idx), 0);
    chk("mid-rst busy", int'(busy), 0);
    chk("mid-rst done", int'(done), 0);
    chk_win("mid-rst window", src_window, '0, weight_window, '0);
    #2 srstn = 1'b1;
    rv0 = rv_cnt;
    dn0 = done_cnt;
    for (int c = 7; c <= 14; c++) begin
      tick();
      chk($sformatf("post-rst res_valid c%0d", c), int'(result_valid), 0);
      chk($sformatf("post-rst busy c%0d", c), int'(busy), 0);
    end
    chk("post-rst valid_pulses", rv_cnt - rv0, 0);
    chk("post-rst done_pulses", done_cnt - dn0, 0);

    // Clean restart from neuron 0.
    run_layer(1'b0, 1'b0, 40, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
